// File: rtl/pe_inst_sequencer.sv
// Instruction sequencer for the PE control decoder: a small program memory
// plus an issue/drain FSM honouring per-instruction repeats and a downstream stall.
module pe_inst_sequencer #(
  parameter int INST_WIDTH   = 64,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [INST_WIDTH-1:0] wr_inst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stall,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  inst_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     pc
);

  localparam int HALT_BIT = 27;
  localparam int RPT_LSB  = 16;
  localparam int RPT_W    = 8;
  localparam int CNT_W    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic                    valid_q, valid_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [RPT_W-1:0]        rep_q, rep_d;
  logic [CNT_W-1:0]        drain_q, drain_d;
  logic                    done_q, done_d;

  logic [INST_WIDTH-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]       nxt_addr;
  logic [INST_WIDTH-1:0]   nxt_inst;
  logic [INST_WIDTH-1:0]   first_inst;

  // NOTE: program storage has no reset; clearing it would turn the array into
  // flops instead of a RAM, and a program is always loaded before use anyway.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem_q[wr_addr] <= wr_inst;
    end
  end

  assign nxt_addr   = pc_q + 1'b1;
  assign nxt_inst   = mem_q[nxt_addr];
  assign first_inst = mem_q[0];

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    rep_d   = rep_q;
    drain_d = drain_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        inst_d  = '0;
        valid_d = 1'b0;
        pc_d    = '0;
        // A coincident write takes the cycle; the start request is dropped.
        if (start && !wr_en) begin
          state_d = S_ISSUE;
          inst_d  = first_inst;
          valid_d = 1'b1;
          rep_d   = first_inst[RPT_LSB +: RPT_W];
        end
      end

      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
          inst_d  = '0;
          valid_d = 1'b0;
          pc_d    = '0;
          rep_d   = '0;
        end else if (!stall) begin
          if (rep_q != '0) begin
            rep_d = rep_q - 1'b1;
          end else if (inst_q[HALT_BIT] || (pc_q == LAST_PC)) begin
            state_d = S_DRAIN;
            inst_d  = '0;
            valid_d = 1'b0;
            drain_d = DRAIN_LOAD;
          end else begin
            pc_d   = nxt_addr;
            inst_d = nxt_inst;
            rep_d  = nxt_inst[RPT_LSB +: RPT_W];
          end
        end
      end

      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          pc_d    = '0;
          drain_d = '0;
        end else if (drain_q <= CNT_W'(1)) begin
          // Counter reaches zero on this edge: finish and report.
          state_d = S_IDLE;
          pc_d    = '0;
          drain_d = '0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rep_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rep_q   <= rep_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  assign inst_out   = inst_q;
  assign inst_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Scoreboard bench for pe_inst_sequencer: expected issue streams come from a
// program-walking reference model; a monitor consumes them on every accepted issue.
module tb_pe_inst_sequencer;

  localparam int INST_WIDTH   = 64;
  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int DRAIN_CYCLES = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [INST_WIDTH-1:0] wr_inst;
  logic                  start;
  logic                  abort;
  logic                  stall;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  inst_valid;
  logic                  busy;
  logic                  done;
  logic [ADDR_W-1:0]     pc;

  pe_inst_sequencer #(
    .INST_WIDTH  (INST_WIDTH),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_inst   (wr_inst),
    .start     (start),
    .abort     (abort),
    .stall     (stall),
    .inst_out  (inst_out),
    .inst_valid(inst_valid),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_W-1:0]     pc;
  } exp_t;

  exp_t                  exp_q[$];
  logic [INST_WIDTH-1:0] tb_mem [DEPTH];
  int                    n_checks   = 0;
  int                    n_errors   = 0;
  int                    drain_wait = 0;
  int                    done_cnt   = 0;
  bit                    aborting   = 1'b0;
  bit                    mon_on     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] sel, input logic [2:0] opc,
                                     input int rpt, input bit halt, input logic [31:0] salt);
    logic [63:0] v;
    v        = {sel, salt[29:0], salt};
    v[26:24] = opc;
    v[23:16] = 8'(rpt);
    v[27]    = halt;
    return v;
  endfunction

  // Reference model: walk the program, each entry issued rpt+1 times,
  // stopping after a halt entry or the last address.
  task automatic build_expected();
    int p = 0;
    exp_q.delete();
    forever begin
      for (int r = 0; r <= int'(tb_mem[p][23:16]); r++)
        exp_q.push_back('{inst: tb_mem[p], pc: ADDR_W'(p)});
      if (tb_mem[p][27] || p == DEPTH - 1) break;
      p++;
    end
  endtask

  task automatic load(input int a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_inst = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (drain_wait > 0) begin
          drain_wait--;
          if (drain_wait == 0) begin
            check("done_pulse", done, 1);
            check("busy_at_done", busy, 0);
            check("pc_at_done", pc, 0);
            done_cnt++;
          end else begin
            check("drain_done_low", done, 0);
            check("drain_busy", busy, 1);
            check("drain_valid", inst_valid, 0);
          end
        end else if (done) begin
          check("spurious_done", done, 0);
        end
        if (inst_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", inst_valid, 0);
          end else if (stall) begin
            check("stall_hold_inst", inst_out, exp_q[0].inst);
            check("stall_hold_pc", pc, exp_q[0].pc);
          end else begin
            e = exp_q.pop_front();
            check("issue_inst", inst_out, e.inst);
            check("issue_pc", pc, e.pc);
            if (exp_q.size() == 0 && !aborting) drain_wait = DRAIN_CYCLES;
          end
        end
      end
    end
  endtask

  // stall_mode: 0 none, 1 random, 2 held on cycles 1-2 after start.
  task automatic run_prog(input int stall_mode, input bit wr_busy);
    int d0 = done_cnt;
    build_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done_cnt != d0) break;
      case (stall_mode)
        0:       stall = 1'b0;
        1:       stall = ($urandom_range(0, 3) == 0);
        default: stall = (cyc == 1 || cyc == 2);
      endcase
      wr_en = wr_busy && (cyc == 1);
      if (wr_en) begin
        wr_addr = '0;
        wr_inst = ~tb_mem[0];
      end
      if (cyc == 0) begin
        @(negedge clk);
        check("first_valid", inst_valid, 1);
        check("busy_after_start", busy, 1);
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    wr_en = 1'b0;
    check("done_count", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_inst = '0;
    start = 1'b0; abort = 1'b0; stall = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inst", inst_out, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // ADD, SUB, MUL(halt): three issues, then drain and done.
    load(0, mk(2'b01, 3'b001, 0, 1'b0, 32'h1111_0001));
    load(1, mk(2'b10, 3'b010, 0, 1'b0, 32'h2222_0002));
    load(2, mk(2'b11, 3'b011, 0, 1'b1, 32'h3333_0003));
    repeat (3) @(posedge clk); #1;
    run_prog(0, 1'b0);

    // Repeat count 2 on the first entry, MULI with halt after it.
    load(0, mk(2'b01, 3'b001, 2, 1'b0, 32'h4444_0004));
    load(1, mk(2'b00, 3'b100, 0, 1'b1, 32'h5555_0005));
    run_prog(0, 1'b0);

    // Four-entry program with a two-cycle stall on the second issue.
    for (int i = 0; i < 4; i++)
      load(i, mk(2'(i), 3'(i + 1), 0, i == 3, 32'hA000_0000 + 32'(i)));
    run_prog(2, 1'b0);

    // No halt anywhere: implicit halt at the last address.
    for (int i = 0; i < DEPTH; i++)
      load(i, mk(2'($urandom), 3'($urandom), 0, 1'b0, $urandom));
    run_prog(0, 1'b0);

    // Abort while pc=1, then a clean rerun from address 0.
    build_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    aborting = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    aborting = 1'b0;
    @(negedge clk);
    check("abort_valid", inst_valid, 0);
    check("abort_inst", inst_out, 0);
    check("abort_pc", pc, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (6) @(posedge clk); #1;
    run_prog(0, 1'b0);

    // A write while busy must be dropped; the rerun sees the old mem[0].
    run_prog(0, 1'b1);
    run_prog(0, 1'b0);

    // Asynchronous reset between edges while draining.
    load(3, mk(2'b01, 3'b101, 0, 1'b1, 32'hBEEF_0003));
    build_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (drain_wait == 2) break;
    end
    check("reached_drain", drain_wait, 2);
    check("drain_busy_pre_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", inst_valid, 0);
    check("async_rst_done", done, 0);
    check("async_rst_pc", pc, 0);
    check("async_rst_inst", inst_out, 0);
    exp_q.delete();
    drain_wait = 0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // start together with wr_en in IDLE: the write happens, no issue starts.
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 2;
    wr_inst = mk(2'b10, 3'b110, 1, 1'b1, 32'hC0DE_0002);
    tb_mem[2] = wr_inst;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check("start_wr_busy", busy, 0);
    check("start_wr_valid", inst_valid, 0);
    @(posedge clk); #1;
    run_prog(0, 1'b0);

    // Randomized programs with repeats, random halts and random stalls.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, mk(2'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), $urandom));
      run_prog(1, 1'b0);
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_inst_sequencer.md
Name: pe_inst_sequencer

Overview:
- Instruction sequencer that feeds the PE control decoder.
- Holds a small program of 64-bit PE instructions, loaded over a write port.
- On `start`, issues the program one instruction per cycle, honouring per-instruction repeat counts and a downstream stall.
- After the last instruction it drains the PE pipeline, then pulses `done`.

Parameters:
- INST_WIDTH, 64, instruction width (matches the PE control instruction bus).
- DEPTH, 16, number of program memory entries.
- ADDR_W, 4, program address width; equals log2(DEPTH).
- DRAIN_CYCLES, 3, idle cycles after the last issue before `done` (covers the control register stage plus DSP latency).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  program write strobe.
- wr_addr  in  ADDR_W  program write address.
- wr_inst  in  INST_WIDTH  program write data.
- start  in  1  begin execution at address 0.
- abort  in  1  synchronous abort of execution.
- stall  in  1  downstream not ready; freeze issue.
- inst_out  out  INST_WIDTH  registered instruction to the PE control `inst` input.
- inst_valid  out  1  `inst_out` is a live issue this cycle.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- pc  out  ADDR_W  address of the instruction currently being issued.

Behaviour:
- Instruction fields used by this block:
  - [63:62] sel: passed through unchanged.
  - [26:24] opcode: passed through unchanged.
  - [27] halt: last instruction of the program.
  - [23:16] rpt: extra issues; the instruction is issued rpt+1 times.
  - All other bits are passed through unchanged.
- Reset (async, `rst`=1): state IDLE; `inst_out`=0, `inst_valid`=0, `busy`=0, `done`=0, `pc`=0; repeat counter and drain counter = 0. Program memory contents are not reset.
- Writes: `mem[wr_addr]<=wr_inst` when `wr_en`=1 and state is IDLE. `wr_en` in any other state is ignored.
- IDLE:
  - `inst_out`=0 (sel 00 / opcode 000 = LOAD, which is a no-op to the decoder).
  - If `start`=1 and `wr_en`=0: go to ISSUE. Simultaneous `start` and `wr_en` → the write wins and `start` is ignored.
- ISSUE, entry: edge N samples `start`; after edge N+1, `inst_out`=mem[0], `inst_valid`=1, `pc`=0, rep counter loaded with mem[0].rpt.
- ISSUE, each edge with `stall`=0:
  - If rep counter > 0: decrement it; `inst_out` re-issued unchanged with `inst_valid`=1.
  - Else if the current instruction has halt=1 or `pc`=DEPTH-1: go to DRAIN; `inst_out`<=0, `inst_valid`<=0, drain counter <= DRAIN_CYCLES-1.
  - Else: `pc`<=pc+1, `inst_out`<=mem[pc+1], rep counter <= mem[pc+1].rpt.
- ISSUE, edge with `stall`=1: `inst_out`, `inst_valid`, `pc` and rep counter all hold. No instruction is lost or duplicated.
- Reaching `pc`=DEPTH-1 acts as an implicit halt. `pc` never wraps.
- DRAIN:
  - Ignores `stall` and `start`.
  - Decrements the drain counter each cycle.
  - When the counter is 0: `done`<=1 for exactly one cycle, state <= IDLE, `pc`<=0.
- `abort`=1 in ISSUE or DRAIN: next edge goes to IDLE; `inst_out`=0, `inst_valid`=0, `pc`=0, no `done` pulse. `abort` has priority over `stall` and the repeat logic. `abort` in IDLE has no effect.
- `busy`=1 in ISSUE and DRAIN. `busy` falls in the same cycle `done` is high.
- Reset asserted mid-program: immediate return to IDLE with all outputs zero. A new `start` reruns from address 0.
- Throughput: one issue per non-stalled cycle. A P-entry program with no repeats and no stalls, started at edge N:
  - `inst_valid` is high for edges N+1..N+P.
  - `done` is high after edge N+P+DRAIN_CYCLES.

Test Plan:
- Write 3 instructions (ADD, SUB, MUL with halt), no repeats, `start` at cycle 10 → `inst_valid` high cycles 11-13 with `inst_out` = mem[0..2] in order; `done` pulse at cycle 16; `busy` high cycles 11-15.
- mem[0] has rpt=2, mem[1] = MULI with halt → mem[0] issued on 3 consecutive cycles, mem[1] once; 4 valid cycles total, then `done` after 3 drain cycles.
- `stall` held for 2 cycles during the second issue of a 4-instruction program → `inst_out` and `pc` frozen for 2 cycles; all 4 instructions still appear exactly once; `done` delayed by 2 cycles.
- No halt bit set anywhere, DEPTH=16 → instructions 0..15 issued, implicit halt at `pc`=15, no wrap to 0; one `done` pulse.
- `abort` asserted during ISSUE at `pc`=1 → next cycle `inst_valid`=0, `inst_out`=0, `pc`=0, `busy`=0, no `done`; a following `start` reissues from mem[0]. Separately, `wr_en` while `busy` leaves mem unchanged, verified on a rerun.
- Async `rst` pulsed between clock edges during DRAIN → outputs clear immediately without waiting for an edge; `start` together with `wr_en` in IDLE → the write occurs and no issue starts.
